// File: rtl/calc_operand_stack.sv
// calc_operand_stack: hex-digit entry register feeding a DEPTH-deep operand/opcode stack
// Ports: clock, reset (synchronous, active-low); newhex/hexcode, newop/opcode, eq/ans are
// level inputs acting once per rising edge; bksp exists only when CALC_BACKSPACE_EN is defined.
// Outputs: V1_reg entry register, V2_reg/op_reg top of stack (0 when empty), depth,
// entry_full (all NDIG digits keyed), err (sticky until reset).
module calc_operand_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       newhex,
  input  logic [3:0]                 hexcode,
  input  logic                       newop,
  input  logic [1:0]                 opcode,
  input  logic                       eq,
  input  logic [WIDTH-1:0]           ans,
`ifdef CALC_BACKSPACE_EN
  input  logic                       bksp,
`endif
  output logic [WIDTH-1:0]           V1_reg,
  output logic [WIDTH-1:0]           V2_reg,
  output logic [1:0]                 op_reg,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       entry_full,
  output logic                       err
);
  localparam int NDIG = WIDTH / 4;
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(NDIG + 1);
  logic [WIDTH-1:0] stk_val [DEPTH];
  logic [1:0]       stk_op  [DEPTH];
  logic [CW-1:0]    ndig;
  logic             fresh;
  logic             prev_hex, prev_op, prev_eq;
  logic             hex_ev, op_ev, eq_ev;
  logic [IW-1:0]    top, push_idx;
  assign hex_ev = newhex & ~prev_hex;
  assign op_ev = newop & ~prev_op;
  assign eq_ev = eq & ~prev_eq;
`ifdef CALC_BACKSPACE_EN
  logic prev_bk;
  logic bk_ev;
  assign bk_ev = bksp & ~prev_bk;
`endif
  assign top = IW'(depth - DW'(1));
  assign push_idx = IW'(depth);
  // top index is meaningless when empty, so the outputs are forced to zero then
  assign V2_reg = depth == '0 ? '0 : stk_val[top];
  assign op_reg = depth == '0 ? '0 : stk_op[top];
  assign entry_full = ndig == CW'(NDIG);
  always_ff @(posedge clock) begin
    if (!reset) begin
      V1_reg <= '0;
      depth <= '0;
      ndig <= '0;
      fresh <= 1'b0;
      err <= 1'b0;
      prev_hex <= 1'b0;
      prev_op <= 1'b0;
      prev_eq <= 1'b0;
`ifdef CALC_BACKSPACE_EN
      prev_bk <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        stk_val[i] <= '0;
        stk_op[i] <= '0;
      end
    end else begin
      prev_hex <= newhex;
      prev_op <= newop;
      prev_eq <= eq;
`ifdef CALC_BACKSPACE_EN
      prev_bk <= bksp;
`endif
      // one event per edge: eq > newop > newhex > bksp, losers are dropped
      if (eq_ev) begin
        if (depth != '0) begin
          V1_reg <= ans;
          depth <= depth - DW'(1);
          ndig <= '0;
          fresh <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end else if (op_ev) begin
        if (depth < DW'(DEPTH)) begin
          stk_val[push_idx] <= V1_reg;
          stk_op[push_idx] <= opcode;
          depth <= depth + DW'(1);
          V1_reg <= '0;
          ndig <= '0;
          fresh <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (hex_ev) begin
        // a digit after eq starts a new entry instead of extending the answer
        if (fresh) begin
          V1_reg <= WIDTH'(hexcode);
          ndig <= CW'(1);
          fresh <= 1'b0;
        end else if (ndig < CW'(NDIG)) begin
          V1_reg <= {V1_reg[WIDTH-5:0], hexcode};
          ndig <= ndig + CW'(1);
        end else begin
          err <= 1'b1;
        end
      end
`ifdef CALC_BACKSPACE_EN
      else if (bk_ev) begin
        if (!fresh && ndig != '0) begin
          V1_reg <= V1_reg >> 4;
          ndig <= ndig - CW'(1);
        end else begin
          V1_reg <= '0;
          ndig <= '0;
          fresh <= 1'b0;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_calc_operand_stack.sv
// tb_calc_operand_stack: self-checking bench for calc_operand_stack at WIDTH=16, DEPTH=4
module tb_calc_operand_stack;
  typedef struct {
    logic rs, nh; logic [3:0] hx; logic no; logic [1:0] oc; logic e; logic [15:0] an; logic bk;
    logic [15:0] v1, v2; logic [1:0] op; logic [2:0] dp; logic ef, er;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic newhex = 1'b0;
  logic [3:0] hexcode = '0;
  logic newop = 1'b0;
  logic [1:0] opcode = '0;
  logic eq = 1'b0;
  logic [15:0] ans = '0;
  logic bksp = 1'b0;
  logic [15:0] V1_reg, V2_reg;
  logic [1:0] op_reg;
  logic [2:0] depth;
  logic entry_full, err;
  vec_t sb[$];
  vec_t tbl[$];
  int errors = 0;
  int checks = 0;
  int row = 0;
  always #5 clock = ~clock;
  calc_operand_stack #(.WIDTH(16), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .newhex(newhex), .hexcode(hexcode), .newop(newop),
    .opcode(opcode), .eq(eq), .ans(ans),
`ifdef CALC_BACKSPACE_EN
    .bksp(bksp),
`endif
    .V1_reg(V1_reg), .V2_reg(V2_reg), .op_reg(op_reg), .depth(depth),
    .entry_full(entry_full), .err(err)
  );
  function automatic vec_t mk(logic rs, logic nh, logic [3:0] hx, logic no, logic [1:0] oc,
                              logic e, logic [15:0] an, logic bk, logic [15:0] v1, logic [15:0] v2,
                              logic [1:0] op, logic [2:0] dp, logic ef, logic er);
    vec_t v;
    v.rs = rs; v.nh = nh; v.hx = hx; v.no = no; v.oc = oc; v.e = e; v.an = an; v.bk = bk;
    v.v1 = v1; v.v2 = v2; v.op = op; v.dp = dp; v.ef = ef; v.er = er;
    return v;
  endfunction
  function automatic vec_t idle(logic [15:0] v1, logic [15:0] v2, logic [1:0] op, logic [2:0] dp,
                                logic ef, logic er);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, v1, v2, op, dp, ef, er);
  endfunction
  function automatic vec_t rst_row();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    vec_t x;
    @(negedge clock);
    reset = v.rs; newhex = v.nh; hexcode = v.hx; newop = v.no; opcode = v.oc;
    eq = v.e; ans = v.an; bksp = v.bk;
    sb.push_back(v);
    @(posedge clock);
    #1;
    x = sb.pop_front();
    chk("V1_reg", V1_reg, x.v1);
    chk("V2_reg", V2_reg, x.v2);
    chk("op_reg", 16'(op_reg), 16'(x.op));
    chk("depth", 16'(depth), 16'(x.dp));
    chk("entry_full", 16'(entry_full), 16'(x.ef));
    chk("err", 16'(err), 16'(x.er));
    row++;
  endtask
  initial begin
    // power-on reset, then newhex held for 9 cycles enters a single digit
    run(rst_row());
    run(rst_row());
    for (int i = 0; i < 9; i++) run(mk(1, 1, 5, 0, 0, 0, 0, 0, 16'h0005, 0, 0, 0, 0, 0));
    run(idle(16'h0005, 0, 0, 0, 0, 0));
    // main table: push, eq reload, fresh entry, overflow, same-cycle priorities
    tbl.push_back(rst_row());
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 16'h0005, 0, 0, 0, 0, 0));
    tbl.push_back(idle(16'h0005, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 16'h0054, 0, 0, 0, 0, 0));
    tbl.push_back(idle(16'h0054, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2, 0, 0, 0, 16'h0000, 16'h0054, 2, 1, 0, 0));
    tbl.push_back(idle(16'h0000, 16'h0054, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 16'h0003, 16'h0054, 2, 1, 0, 0));
    tbl.push_back(idle(16'h0003, 16'h0054, 2, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 16'h0033, 16'h0054, 2, 1, 0, 0));
    tbl.push_back(idle(16'h0033, 16'h0054, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 16'h0087, 0, 16'h0087, 0, 0, 0, 0, 0));
    tbl.push_back(idle(16'h0087, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 16'h0009, 0, 0, 0, 0, 0));
    tbl.push_back(idle(16'h0009, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 16'h0091, 0, 0, 0, 0, 0));
    tbl.push_back(idle(16'h0091, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 16'h0912, 0, 0, 0, 0, 0));
    tbl.push_back(idle(16'h0912, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 16'h9123, 0, 0, 0, 1, 0));
    tbl.push_back(idle(16'h9123, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 16'h9123, 0, 0, 0, 1, 1));
    tbl.push_back(idle(16'h9123, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 7, 1, 1, 0, 0, 0, 16'h0000, 16'h9123, 1, 1, 0, 1));
    tbl.push_back(idle(16'h0000, 16'h9123, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3, 1, 16'h1111, 0, 16'h1111, 0, 0, 0, 0, 1));
    tbl.push_back(idle(16'h1111, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 4'ha, 0, 0, 0, 0, 0, 16'h000a, 0, 0, 0, 0, 1));
    foreach (tbl[i]) run(tbl[i]);
    // five digits at WIDTH=16: the fifth is refused
    run(rst_row());
    run(mk(1, 1, 1, 0, 0, 0, 0, 0, 16'h0001, 0, 0, 0, 0, 0));
    run(idle(16'h0001, 0, 0, 0, 0, 0));
    run(mk(1, 1, 2, 0, 0, 0, 0, 0, 16'h0012, 0, 0, 0, 0, 0));
    run(idle(16'h0012, 0, 0, 0, 0, 0));
    run(mk(1, 1, 3, 0, 0, 0, 0, 0, 16'h0123, 0, 0, 0, 0, 0));
    run(idle(16'h0123, 0, 0, 0, 0, 0));
    run(mk(1, 1, 4, 0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 1, 0));
    run(idle(16'h1234, 0, 0, 0, 1, 0));
    run(mk(1, 1, 5, 0, 0, 0, 0, 0, 16'h1234, 0, 0, 0, 1, 1));
    // fill the stack with entries 1..4 (opcode k-1), then overflow it
    run(rst_row());
    for (int k = 1; k <= 4; k++) begin
      run(mk(1, 1, 4'(k), 0, 0, 0, 0, 0, 16'(k), k == 1 ? 16'h0 : 16'(k - 1),
             k == 1 ? 2'd0 : 2'(k - 2), 3'(k - 1), 0, 0));
      run(idle(16'(k), k == 1 ? 16'h0 : 16'(k - 1), k == 1 ? 2'd0 : 2'(k - 2), 3'(k - 1), 0, 0));
      run(mk(1, 0, 0, 1, 2'(k - 1), 0, 0, 0, 16'h0, 16'(k), 2'(k - 1), 3'(k), 0, 0));
      run(idle(16'h0, 16'(k), 2'(k - 1), 3'(k), 0, 0));
    end
    run(mk(1, 1, 5, 0, 0, 0, 0, 0, 16'h0005, 16'h0004, 3, 4, 0, 0));
    run(idle(16'h0005, 16'h0004, 3, 4, 0, 0));
    run(mk(1, 0, 0, 1, 1, 0, 0, 0, 16'h0005, 16'h0004, 3, 4, 0, 1));
    // eq on an empty stack leaves V1 alone and flags err
    run(rst_row());
    run(mk(1, 1, 7, 0, 0, 0, 0, 0, 16'h0007, 0, 0, 0, 0, 0));
    run(idle(16'h0007, 0, 0, 0, 0, 0));
    run(mk(1, 0, 0, 0, 0, 1, 16'hffff, 0, 16'h0007, 0, 0, 0, 0, 1));
    run(idle(16'h0007, 0, 0, 0, 0, 1));
    // reset beats a same-cycle event; input high at release fires once
    run(mk(1, 1, 3, 0, 0, 0, 0, 0, 16'h0073, 0, 0, 0, 0, 1));
    run(mk(0, 1, 6, 1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0));
    run(mk(1, 1, 6, 0, 0, 0, 0, 0, 16'h0006, 0, 0, 0, 0, 0));
    run(mk(1, 1, 8, 0, 0, 0, 0, 0, 16'h0006, 0, 0, 0, 0, 0));
`ifdef CALC_BACKSPACE_EN
    run(rst_row());
    run(mk(1, 1, 4'ha, 0, 0, 0, 0, 0, 16'h000a, 0, 0, 0, 0, 0));
    run(idle(16'h000a, 0, 0, 0, 0, 0));
    run(mk(1, 1, 4'hb, 0, 0, 0, 0, 0, 16'h00ab, 0, 0, 0, 0, 0));
    run(idle(16'h00ab, 0, 0, 0, 0, 0));
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, 16'h000a, 0, 0, 0, 0, 0));
    run(idle(16'h000a, 0, 0, 0, 0, 0));
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0));
    run(idle(16'h0000, 0, 0, 0, 0, 0));
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 0, 0));
    run(idle(16'h0000, 0, 0, 0, 0, 0));
    run(mk(1, 1, 4'hc, 0, 0, 0, 0, 0, 16'h000c, 0, 0, 0, 0, 0));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
